// File: rtl/sram_controller.sv
// sram_controller: serves 32-bit Mem-stage read/write requests as two sequential
// 16-bit accesses on an external asynchronous SRAM.
// ready stays low while a request is in flight and acts as a pipeline freeze.
module sram_controller #(
    parameter int BASE_ADDR   = 1024,
    parameter int SRAM_ADDR_W = 18,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rd_en,
    input  logic                   wr_en,
    input  logic [31:0]            address,
    input  logic [31:0]            wdata,
    output logic [31:0]            rdata,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [15:0]            sram_dq_o,
    input  logic [15:0]            sram_dq_i,
    output logic                   sram_dq_oe,
    output logic                   sram_we_n,
    output logic                   sram_oe_n
);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    state_t                 state;
    logic [2:0]             cnt;
    logic                   op_wr;
    logic [SRAM_ADDR_W-2:0] word;
    logic [31:0]            wdata_q;
    logic [15:0]            rdata_low_q;

    logic [31:0]            req_off;
    logic [SRAM_ADDR_W-2:0] req_word;
    logic                   req;
    logic                   phase_end;
    logic                   unused_off_bits;

    // Offset into the SRAM; only the word index within the SRAM size matters,
    // so byte-lane bits and bits above the SRAM size are dropped (aliasing).
    assign req_off         = address - 32'(BASE_ADDR);
    assign req_word        = req_off[SRAM_ADDR_W:2];
    assign unused_off_bits = ^{req_off[31:SRAM_ADDR_W+1], req_off[1:0]};

    assign req       = rd_en | wr_en;
    assign phase_end = (cnt == 3'(WAIT_CYCLES));

    // ready drops in the request cycle itself so the freeze is immediate.
    assign ready = rst | ((state == IDLE) ? ~req : (state == DONE));

    // Main FSM: bus outputs are registered and loaded on the edge entering each phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= 3'd0;
            op_wr       <= 1'b0;
            word        <= '0;
            wdata_q     <= 32'd0;
            rdata_low_q <= 16'd0;
            rdata       <= 32'd0;
            sram_addr   <= '0;
            sram_dq_o   <= 16'd0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        // Write wins when both requests are asserted.
                        state      <= LOW;
                        cnt        <= 3'd0;
                        op_wr      <= wr_en;
                        word       <= req_word;
                        wdata_q    <= wdata;
                        sram_addr  <= {req_word, 1'b0};
                        sram_dq_o  <= wdata[15:0];
                        sram_we_n  <= ~wr_en;
                        sram_oe_n  <= wr_en;
                        sram_dq_oe <= wr_en;
                    end
                end
                LOW: begin
                    if (phase_end) begin
                        state     <= HIGH;
                        cnt       <= 3'd0;
                        if (!op_wr) rdata_low_q <= sram_dq_i;
                        sram_addr <= {word, 1'b1};
                        sram_dq_o <= wdata_q[31:16];
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                HIGH: begin
                    if (phase_end) begin
                        state      <= DONE;
                        cnt        <= 3'd0;
                        if (!op_wr) rdata <= {sram_dq_i, rdata_low_q};
                        sram_addr  <= '0;
                        sram_dq_o  <= 16'd0;
                        sram_we_n  <= 1'b1;
                        sram_oe_n  <= 1'b1;
                        sram_dq_oe <= 1'b0;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                DONE: begin
                    // The request still present here is the one completing; never re-accept it.
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
